board_input_conditioner: RTL and testbench
==========================================

Name: board_input_conditioner

Overview:
- Conditions the raw asynchronous board switches and push-buttons before they reach the PULPino GPIO inputs and the fetch-enable path in the Zedboard emulation top.
- Sits directly upstream of the top-level GPIO mapping, between the board pins and the SoC.
- Per input: 2-flop synchronizer, then a counter-based debouncer.
- Produces debounced levels, single-cycle button rise/fall pulses, a switch-change pulse, and a sticky button-event interrupt flag with clear.

Parameters:
N_SW, 8, number of slide switches
N_BTN, 5, number of push-buttons
DEBOUNCE_CYCLES, 20000, consecutive stable cycles required to accept a new level (>=2)
CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived)

Ports:
clk_i  in  1  block clock (pulpino clock domain)
rst_i  in  1  reset, synchronous, active-high
sw_i  in  N_SW  raw asynchronous switch pins
btn_i  in  N_BTN  raw asynchronous button pins
irq_clr_i  in  1  clears the sticky irq_o flag
sw_o  out  N_SW  debounced switch levels
btn_o  out  N_BTN  debounced button levels
btn_rise_o  out  N_BTN  1-cycle pulse on debounced 0->1
btn_fall_o  out  N_BTN  1-cycle pulse on debounced 1->0
sw_change_o  out  1  1-cycle pulse when any debounced switch bit changes
fetch_en_o  out  1  equals sw_o[0]
irq_o  out  1  sticky flag, set by any btn_rise_o bit

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk_i.
- Reset clears all sync flops, stable registers, counters and pulse registers. All outputs are 0 in the cycle after reset is sampled, including fetch_en_o and irq_o.
- Reset asserted mid-count aborts the count. No pulse is generated for the aborted count.

Synchronizer:
- Two flops per bit. The second stage (syncd) is the only value the debouncer sees.

Debouncer (independent per bit; stable register st, counter cnt):
- syncd == st: cnt <= 0.
- syncd != st and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
- syncd != st and cnt == DEBOUNCE_CYCLES-1: st <= syncd, cnt <= 0, edge pulse registered in the same edge.
- Any single cycle where syncd returns to st restarts the count from 0. There is no partial credit.

Latency:
- A clean input change first sampled at edge 1 appears on the output after edge DEBOUNCE_CYCLES+2.
- Pulses are asserted in that same cycle, for exactly one cycle.

Pulses:
- btn_rise_o[i] / btn_fall_o[i] are registered and mutually exclusive per bit.
- sw_change_o is the OR of all switch-bit updates in a cycle. Multiple simultaneous switch updates give one pulse.

IRQ:
- irq_o <= (irq_o & ~irq_clr_i) | (|btn_rise_o).
- Set has priority: if a rise pulse and irq_clr_i coincide, irq_o stays/becomes 1.
- btn_fall_o does not affect irq_o.

Other rules:
- fetch_en_o is combinationally sw_o[0], with no extra latency.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
- No combinational path from any input to any output.

Test Plan:
1. DEBOUNCE_CYCLES=4. Assert rst_i, then drop it -> all outputs 0. Set sw_i=8'hA5 and hold -> sw_o=8'hA5 exactly 6 edges later; sw_change_o high for 1 cycle; fetch_en_o=1.
2. DEBOUNCE_CYCLES=4. btn_i[2] glitches high for 3 cycles, then low -> btn_o stays 0, no btn_rise_o, irq_o=0. Repeat with a 1-cycle low dropout inside a 6-cycle high -> counter restarts; btn_o rises only after 4 clean synced cycles.
3. btn_i[0] press held -> btn_rise_o=5'b00001 for 1 cycle, irq_o=1 next cycle. Release -> btn_fall_o=5'b00001 for 1 cycle, irq_o remains 1. Pulse irq_clr_i -> irq_o=0.
4. irq_clr_i asserted in the same cycle as btn_rise_o[3] -> irq_o=1 afterwards (set wins).
5. btn_i=5'b11111 and sw_i=8'hFF changed on the same edge -> all btn_rise_o bits pulse together in one cycle; a single sw_change_o pulse.
6. rst_i asserted when cnt=2 of 4 mid-debounce -> no pulse, outputs 0. After rst_i drops with the input still changed, the full 6-edge latency is observed again.

Source files
------------

// File: rtl/board_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// board_input_conditioner_if
//   Bundles the board-side pins and the conditioned outputs of
//   board_input_conditioner.
//
//   Signals:
//     sw_i        raw asynchronous slide-switch pins       (N_SW bits)
//     btn_i       raw asynchronous push-button pins        (N_BTN bits)
//     irq_clr_i   clears the sticky button-event flag
//     sw_o        debounced switch levels                  (N_SW bits)
//     btn_o       debounced button levels                  (N_BTN bits)
//     btn_rise_o  1-cycle pulse on debounced button 0->1   (N_BTN bits)
//     btn_fall_o  1-cycle pulse on debounced button 1->0   (N_BTN bits)
//     sw_change_o 1-cycle pulse when any debounced switch changes
//     fetch_en_o  debounced switch 0
//     irq_o       sticky flag set by any button rise
//
//   Modports:
//     master  board / SoC side: drives the raw pins, consumes the results
//     slave   the conditioner itself
// -----------------------------------------------------------------------------
interface board_input_conditioner_if #(
    parameter int N_SW  = 8,
    parameter int N_BTN = 5
);
    logic [N_SW-1:0]  sw_i;
    logic [N_BTN-1:0] btn_i;
    logic             irq_clr_i;
    logic [N_SW-1:0]  sw_o;
    logic [N_BTN-1:0] btn_o;
    logic [N_BTN-1:0] btn_rise_o;
    logic [N_BTN-1:0] btn_fall_o;
    logic             sw_change_o;
    logic             fetch_en_o;
    logic             irq_o;

    modport master (
        output sw_i, btn_i, irq_clr_i,
        input  sw_o, btn_o, btn_rise_o, btn_fall_o, sw_change_o, fetch_en_o, irq_o
    );

    modport slave (
        input  sw_i, btn_i, irq_clr_i,
        output sw_o, btn_o, btn_rise_o, btn_fall_o, sw_change_o, fetch_en_o, irq_o
    );
endinterface

// File: rtl/board_input_conditioner.sv
// -----------------------------------------------------------------------------
// board_input_conditioner
//   Conditions raw board switches and push-buttons before they reach the
//   SoC GPIO inputs and the fetch-enable path. Every input bit goes through
//   a 2-flop synchronizer followed by a counter-based debouncer that accepts
//   a new level only after DEBOUNCE_CYCLES consecutive synced samples that
//   differ from the current stable level.
//
//   Ports:
//     clk_i   block clock
//     rst_i   synchronous active-high reset
//     bus     board_input_conditioner_if.slave
//               in : sw_i, btn_i, irq_clr_i
//               out: sw_o, btn_o, btn_rise_o, btn_fall_o, sw_change_o,
//                    fetch_en_o, irq_o
//
//   Every output is driven straight from a register (fetch_en_o is a wire
//   copy of the registered sw_o[0]), so no input reaches an output
//   combinationally.
// -----------------------------------------------------------------------------
module board_input_conditioner #(
    parameter int N_SW            = 8,
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    board_input_conditioner_if.slave      bus
);

    // Switches and buttons share one debouncer vector: switches in the low
    // bits, buttons above them.
    localparam int N_IN = N_SW + N_BTN;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  sync_p0;
    logic [N_IN-1:0]  sync_p1;
    logic [N_IN-1:0]  st_p2;
    logic [CNT_W-1:0] cnt_p2 [N_IN];
    logic [N_IN-1:0]  upd;

    logic [N_BTN-1:0] btn_rise_p2;
    logic [N_BTN-1:0] btn_fall_p2;
    logic             sw_change_p2;
    logic             irq_p3;

    // A bit is accepted on the edge where it has differed from the stable
    // level for the DEBOUNCE_CYCLES-th consecutive cycle.
    always_comb begin
        upd = '0;
        for (int i = 0; i < N_IN; i++) begin
            upd[i] = (sync_p1[i] != st_p2[i]) && (cnt_p2[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p0      <= '0;
            sync_p1      <= '0;
            st_p2        <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_p2[i] <= '0;
            end
            btn_rise_p2  <= '0;
            btn_fall_p2  <= '0;
            sw_change_p2 <= 1'b0;
            irq_p3       <= 1'b0;
        end else begin
            // Stage p0/p1: two-flop synchronizer
            sync_p0 <= {bus.btn_i, bus.sw_i};
            sync_p1 <= sync_p0;

            // Stage p2: debounce; any sample matching st restarts the count
            for (int i = 0; i < N_IN; i++) begin
                if (sync_p1[i] == st_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_MAX) begin
                    st_p2[i]  <= sync_p1[i];
                    cnt_p2[i] <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
                end
            end

            // Pulses registered on the same edge as the level update; the
            // new level is the synced value, so it picks rise vs fall.
            btn_rise_p2  <= upd[N_IN-1:N_SW] &  sync_p1[N_IN-1:N_SW];
            btn_fall_p2  <= upd[N_IN-1:N_SW] & ~sync_p1[N_IN-1:N_SW];
            sw_change_p2 <= |upd[N_SW-1:0];

            // Stage p3: sticky flag, a rise pulse outranks a clear
            irq_p3 <= (irq_p3 & ~bus.irq_clr_i) | (|btn_rise_p2);
        end
    end

    assign bus.sw_o        = st_p2[N_SW-1:0];
    assign bus.btn_o       = st_p2[N_IN-1:N_SW];
    assign bus.btn_rise_o  = btn_rise_p2;
    assign bus.btn_fall_o  = btn_fall_p2;
    assign bus.sw_change_o = sw_change_p2;
    assign bus.fetch_en_o  = st_p2[0];
    assign bus.irq_o       = irq_p3;

endmodule

// File: tb/tb_board_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_board_input_conditioner
//   Directed scenarios followed by randomized pin activity, all compared each
//   cycle against a window-based reference model: a level is accepted once the
//   last D synchronized samples all equal the opposite of the current level.
// -----------------------------------------------------------------------------
module tb_board_input_conditioner;

    localparam int D    = 4;
    localparam int NSW  = 8;
    localparam int NBTN = 5;
    localparam int NIN  = NSW + NBTN;

    logic clk;
    logic rst;

    board_input_conditioner_if #(.N_SW(NSW), .N_BTN(NBTN)) bus ();

    board_input_conditioner #(
        .N_SW(NSW), .N_BTN(NBTN), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [NIN-1:0]  m_s0, m_s1, m_st;
    logic [D-1:0]    m_hist [NIN];
    logic [NBTN-1:0] m_rise, m_fall;
    logic            m_chg, m_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [NIN-1:0] raw;
        logic [NIN-1:0] acc;
        raw = {bus.btn_i, bus.sw_i};
        acc = '0;
        if (rst) begin
            m_s0 = '0; m_s1 = '0; m_st = '0;
            for (int i = 0; i < NIN; i++) m_hist[i] = '0;
            m_rise = '0; m_fall = '0; m_chg = 1'b0; m_irq = 1'b0;
        end else begin
            m_irq = (m_irq & ~bus.irq_clr_i) | (|m_rise);
            for (int i = 0; i < NIN; i++) begin
                m_hist[i] = {m_hist[i][D-2:0], m_s1[i]};
                if (m_hist[i] == {D{~m_st[i]}}) acc[i] = 1'b1;
            end
            m_rise = acc[NIN-1:NSW] & ~m_st[NIN-1:NSW];
            m_fall = acc[NIN-1:NSW] &  m_st[NIN-1:NSW];
            m_chg  = |acc[NSW-1:0];
            m_st   = m_st ^ acc;
            m_s1   = m_s0;
            m_s0   = raw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("sw_o",        32'(bus.sw_o),        32'(m_st[NSW-1:0]));
        chk("btn_o",       32'(bus.btn_o),       32'(m_st[NIN-1:NSW]));
        chk("btn_rise_o",  32'(bus.btn_rise_o),  32'(m_rise));
        chk("btn_fall_o",  32'(bus.btn_fall_o),  32'(m_fall));
        chk("sw_change_o", 32'(bus.sw_change_o), 32'(m_chg));
        chk("fetch_en_o",  32'(bus.fetch_en_o),  32'(m_st[0]));
        chk("irq_o",       32'(bus.irq_o),       32'(m_irq));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sw_o"},  32'(bus.sw_o),  32'h0);
        chk({tag, "_btn_o"}, 32'(bus.btn_o), 32'h0);
        chk({tag, "_pulses"},
            32'({bus.btn_rise_o, bus.btn_fall_o, bus.sw_change_o}), 32'h0);
        chk({tag, "_fetch_irq"}, 32'({bus.fetch_en_o, bus.irq_o}), 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.sw_i      = '0;
        bus.btn_i     = '0;
        bus.irq_clr_i = 1'b0;

        // 1: reset, then switch pattern latency
        ticks(2);
        rst = 1'b0;
        tick();
        chk_all_zero("t1_reset");
        bus.sw_i = 8'hA5;
        ticks(5);
        chk("t1_sw_before", 32'(bus.sw_o), 32'h0);
        tick();
        chk("t1_sw_after", 32'(bus.sw_o), 32'hA5);
        chk("t1_chg", 32'(bus.sw_change_o), 32'h1);
        chk("t1_fetch", 32'(bus.fetch_en_o), 32'h1);
        tick();
        chk("t1_chg_end", 32'(bus.sw_change_o), 32'h0);

        // 2: 3-cycle glitch rejected, then dropout restarts the count
        bus.btn_i = 5'b00100;
        ticks(3);
        bus.btn_i = 5'b00000;
        ticks(8);
        chk("t2_glitch_btn", 32'(bus.btn_o), 32'h0);
        chk("t2_glitch_irq", 32'(bus.irq_o), 32'h0);
        bus.btn_i = 5'b00100;
        ticks(2);
        bus.btn_i = 5'b00000;
        tick();
        bus.btn_i = 5'b00100;
        ticks(5);
        chk("t2_dropout_wait", 32'(bus.btn_o), 32'h0);
        tick();
        chk("t2_dropout_rise", 32'(bus.btn_o), 32'h04);
        bus.btn_i = 5'b00000;
        ticks(8);
        bus.irq_clr_i = 1'b1;
        tick();
        bus.irq_clr_i = 1'b0;
        tick();

        // 3: press / release of button 0, then clear
        chk("t3_irq_pre", 32'(bus.irq_o), 32'h0);
        bus.btn_i = 5'b00001;
        ticks(6);
        chk("t3_rise", 32'(bus.btn_rise_o), 32'h01);
        tick();
        chk("t3_rise_end", 32'(bus.btn_rise_o), 32'h0);
        chk("t3_irq_set", 32'(bus.irq_o), 32'h1);
        bus.btn_i = 5'b00000;
        ticks(6);
        chk("t3_fall", 32'(bus.btn_fall_o), 32'h01);
        tick();
        chk("t3_irq_keep", 32'(bus.irq_o), 32'h1);
        bus.irq_clr_i = 1'b1;
        tick();
        bus.irq_clr_i = 1'b0;
        chk("t3_irq_clr", 32'(bus.irq_o), 32'h0);

        // 4: clear coinciding with a rise pulse, set wins
        bus.btn_i = 5'b01000;
        ticks(6);
        chk("t4_rise", 32'(bus.btn_rise_o), 32'h08);
        bus.irq_clr_i = 1'b1;
        tick();
        bus.irq_clr_i = 1'b0;
        chk("t4_irq_setwins", 32'(bus.irq_o), 32'h1);
        bus.btn_i = 5'b00000;
        ticks(8);

        // 5: everything changes on the same edge
        bus.btn_i = 5'b11111;
        bus.sw_i  = 8'hFF;
        ticks(6);
        chk("t5_rise_all", 32'(bus.btn_rise_o), 32'h1F);
        chk("t5_chg", 32'(bus.sw_change_o), 32'h1);
        tick();
        chk("t5_chg_single", 32'(bus.sw_change_o), 32'h0);
        chk("t5_rise_end", 32'(bus.btn_rise_o), 32'h0);

        // 6: reset mid-debounce aborts, full latency afterwards
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.btn_i = '0;
        bus.sw_i  = 8'h3C;
        ticks(4);
        rst = 1'b1;
        tick();
        chk_all_zero("t6_abort");
        rst = 1'b0;
        ticks(5);
        chk("t6_wait", 32'(bus.sw_o), 32'h0);
        tick();
        chk("t6_sw", 32'(bus.sw_o), 32'h3C);
        chk("t6_chg", 32'(bus.sw_change_o), 32'h1);

        // Randomized pin activity
        for (int seg = 0; seg < 80; seg++) begin
            int hold;
            bus.sw_i  = 8'($urandom);
            bus.btn_i = 5'($urandom);
            hold = $urandom_range(1, 9);
            for (int c = 0; c < hold; c++) begin
                bus.irq_clr_i = ($urandom_range(0, 7) == 0);
                rst           = ($urandom_range(0, 99) == 0);
                tick();
            end
        end
        rst           = 1'b0;
        bus.irq_clr_i = 1'b0;
        ticks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
